// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared encodings for the multicycle ARM controller (states, cond codes, selects)
package arm_mc_pkg;
    typedef logic [3:0] state_t;

    localparam state_t FETCH    = 4'd0;
    localparam state_t DECODE   = 4'd1;
    localparam state_t MEMADR   = 4'd2;
    localparam state_t MEMREAD  = 4'd3;
    localparam state_t MEMWB    = 4'd4;
    localparam state_t MEMWRITE = 4'd5;
    localparam state_t EXECUTER = 4'd6;
    localparam state_t EXECUTEI = 4'd7;
    localparam state_t ALUWB    = 4'd8;
    localparam state_t BRANCH   = 4'd9;
    localparam state_t UNDEF    = 4'd10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // nzcv = {N, Z, C, V}; the NV encoding (1111) never executes
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/arm_mc_condlogic.sv
// arm_mc_condlogic: NZCV flags register, condition evaluation and write-strobe gating
module arm_mc_condlogic import arm_mc_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic [3:0] rd,
    input  logic       next_pc,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       branch,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write
);
    logic [3:0] flags;
    logic       cond_ex;
    logic       pcs;

    assign cond_ex = cond_holds(cond, flags);
    assign pcs     = ((rd == 4'hF) & reg_w) | branch;

    // NZ and CV are written independently so logical ops leave carry/overflow alone
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_w[1] & cond_ex) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] & cond_ex) flags[1:0] <= alu_flags[1:0];
        end
    end

    assign pc_write  = ~reset & (next_pc | (pcs & cond_ex));
    assign reg_write = ~reset & reg_w & cond_ex;
    assign mem_write = ~reset & mem_w & cond_ex;
endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle ARM control unit (decode, sequencing FSM, conditional strobes); ARM_MC_CTRL_UNDEF_TRAP_EN adds the UNDEF trap and Undef port
module arm_mc_controller import arm_mc_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] RegSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUControl
`ifdef ARM_MC_CTRL_UNDEF_TRAP_EN
    ,
    output logic       Undef
`endif
);
    state_t     state, state_n;
    logic       next_pc, reg_w, mem_w, branch, alu_op, ir_w;
    logic       cmd_add, cmd_sub, cmd_and, cmd_orr;
    logic [1:0] flag_w;

    assign ImmSrc = Op;
    assign RegSrc = {Op == OP_MEM, Op == OP_BR};

    assign cmd_add = Funct[4:1] == 4'b0100;
    assign cmd_sub = Funct[4:1] == 4'b0010;
    assign cmd_and = Funct[4:1] == 4'b0000;
    assign cmd_orr = Funct[4:1] == 4'b1100;

    assign ALUControl = !alu_op ? ALU_ADD : cmd_sub ? ALU_SUB : cmd_and ? ALU_AND :
                        cmd_orr ? ALU_ORR : ALU_ADD;
    assign flag_w = (alu_op & (cmd_add | cmd_sub | cmd_and | cmd_orr)) ?
                    {Funct[0], Funct[0] & (cmd_add | cmd_sub)} : 2'b00;
    assign IRWrite = ir_w & ~reset;

`ifdef ARM_MC_CTRL_UNDEF_TRAP_EN
    assign Undef = state == UNDEF;
`endif

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? FETCH : state_n;
    end

    // sequencing: decode chooses the instruction class, everything else is a fixed walk
    always_comb begin
        state_n = FETCH;
        case (state)
            FETCH:    state_n = DECODE;
            DECODE:   case (Op)
                          OP_MEM:  state_n = MEMADR;
                          OP_DP:   state_n = Funct[5] ? EXECUTEI : EXECUTER;
                          OP_BR:   state_n = BRANCH;
`ifdef ARM_MC_CTRL_UNDEF_TRAP_EN
                          default: state_n = UNDEF;
`else
                          default: state_n = FETCH;
`endif
                      endcase
            MEMADR:   state_n = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_n = MEMWB;
            EXECUTER: state_n = ALUWB;
            EXECUTEI: state_n = ALUWB;
`ifdef ARM_MC_CTRL_UNDEF_TRAP_EN
            UNDEF:    state_n = UNDEF;
`endif
            default:  state_n = FETCH;
        endcase
    end

    // per-state datapath selects and ungated strobes
    always_comb begin
        ir_w      = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        case (state)
            FETCH:    begin ir_w = 1'b1; ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALU; next_pc = 1'b1; end
            DECODE:   begin ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALU; end
            MEMADR:   ALUSrcB = SRCB_IMM;
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB:    begin ResultSrc = RES_DATA; reg_w = 1'b1; end
            MEMWRITE: begin AdrSrc = 1'b1; mem_w = 1'b1; end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin ALUSrcB = SRCB_IMM; alu_op = 1'b1; end
            ALUWB:    reg_w = 1'b1;
            BRANCH:   begin ALUSrcB = SRCB_IMM; ResultSrc = RES_ALU; branch = 1'b1; end
            default:  ;
        endcase
    end

    arm_mc_condlogic u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (Cond),
        .alu_flags (ALUFlags),
        .flag_w    (flag_w),
        .rd        (Rd),
        .next_pc   (next_pc),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .branch    (branch),
        .pc_write  (PCWrite),
        .reg_write (RegWrite),
        .mem_write (MemWrite)
    );
endmodule
